// File: rtl/scanchain_pkg.sv
// Shared scan-chain constants and the write-arbiter state encoding.
package scanchain_pkg;

  localparam int SC_ADDR_BITS    = 12;
  localparam int SC_PAYLOAD_BITS = 169;

  // IDLE: skid buffer empty; ISSUE: buffer full and presented to the writer
  typedef enum logic [0:0] {
    ARB_IDLE  = 1'b0,
    ARB_ISSUE = 1'b1
  } arb_state_t;

endpackage

// File: rtl/scanchain_write_arbiter_picker.sv
// Round-robin priority picker: first set request at or after ptr, wrapping mod N.
module rr_priority_picker #(
  parameter int N        = 2,
  parameter int IDX_BITS = $clog2(N)
) (
  input  logic [N-1:0]        req,
  input  logic [IDX_BITS-1:0] ptr,
  output logic [N-1:0]        grant,
  output logic [IDX_BITS-1:0] idx,
  output logic                any
);

  // Scan ptr, ptr+1, ... and latch onto the first requester found
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!any && req[(int'(ptr) + k) % N]) begin
        any                        = 1'b1;
        grant[(int'(ptr) + k) % N] = 1'b1;
        idx                        = IDX_BITS'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/scanchain_write_arbiter.sv
// Shares one scanchain_writer between NUM_REQ write sources. Round-robin
// arbitration with an optional per-requester lock, feeding a one-entry
// skid buffer that is presented to the writer.
module scanchain_write_arbiter
  import scanchain_pkg::*;
#(
  parameter int NUM_REQ      = 2,
  parameter int ADDR_BITS    = SC_ADDR_BITS,
  parameter int PAYLOAD_BITS = SC_PAYLOAD_BITS,
  parameter int ID_BITS      = $clog2(NUM_REQ)
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [NUM_REQ-1:0]              req_valid,
  output logic [NUM_REQ-1:0]              req_ready,
  input  logic [NUM_REQ-1:0]              req_lock,
  input  logic [NUM_REQ*ADDR_BITS-1:0]    req_addr,
  input  logic [NUM_REQ*PAYLOAD_BITS-1:0] req_payload,
  input  logic [NUM_REQ-1:0]              req_reset,
  output logic                            wr_valid,
  input  logic                            wr_ready,
  output logic [ADDR_BITS-1:0]            wr_addr,
  output logic [PAYLOAD_BITS-1:0]         wr_payload,
  output logic                            wr_reset,
  output logic [ID_BITS-1:0]              grant_id,
  output logic                            busy
);

  arb_state_t                state_reg;
  logic [ID_BITS-1:0]        ptr_reg;
  logic [ID_BITS-1:0]        grant_id_reg;
  logic [ID_BITS-1:0]        lock_owner_reg;
  logic                      lock_valid_reg;
  logic                      wr_valid_reg;
  logic                      busy_reg;
  logic [ADDR_BITS-1:0]      wr_addr_reg;
  logic [PAYLOAD_BITS-1:0]   wr_payload_reg;
  logic                      wr_reset_reg;

  logic [ADDR_BITS-1:0]      addr_arr    [NUM_REQ];
  logic [PAYLOAD_BITS-1:0]   payload_arr [NUM_REQ];

  logic [NUM_REQ-1:0]        owner_onehot;
  logic                      lock_hold;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        pick_grant;
  logic [ID_BITS-1:0]        pick_idx;
  logic                      pick_any;
  logic                      is_idle;
  logic                      transfer;
  logic                      handshake;
  logic [ID_BITS-1:0]        ptr_next;

  // Unpack the flat request buses into per-requester slices
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign addr_arr[gi]    = req_addr[gi*ADDR_BITS +: ADDR_BITS];
      assign payload_arr[gi] = req_payload[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  endgenerate

  // One-hot mask of the current lock owner
  always_comb begin
    owner_onehot                 = '0;
    owner_onehot[lock_owner_reg] = 1'b1;
  end

  // The lock only holds while the owner keeps req_lock high; dropping it
  // opens arbitration to everyone in that same cycle.
  assign lock_hold = lock_valid_reg & req_lock[lock_owner_reg];
  assign eligible  = lock_hold ? (req_valid & owner_onehot) : req_valid;

  rr_priority_picker #(
    .N        (NUM_REQ),
    .IDX_BITS (ID_BITS)
  ) u_picker (
    .req   (eligible),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign is_idle   = (state_reg == ARB_IDLE);
  assign req_ready = is_idle ? pick_grant : '0;
  assign transfer  = is_idle & pick_any;
  assign handshake = wr_valid_reg & wr_ready;
  assign ptr_next  = (pick_idx == ID_BITS'(NUM_REQ - 1)) ? '0 : pick_idx + ID_BITS'(1);

  // Arbitration FSM: capture the winner into the buffer, hold until the writer takes it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ARB_IDLE;
      ptr_reg        <= '0;
      grant_id_reg   <= '0;
      lock_owner_reg <= '0;
      lock_valid_reg <= 1'b0;
      wr_valid_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      wr_addr_reg    <= '0;
      wr_payload_reg <= '0;
      wr_reset_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (transfer) begin
            wr_addr_reg    <= addr_arr[pick_idx];
            wr_payload_reg <= payload_arr[pick_idx];
            wr_reset_reg   <= req_reset[pick_idx];
            grant_id_reg   <= pick_idx;
            ptr_reg        <= ptr_next;
            lock_owner_reg <= pick_idx;
            lock_valid_reg <= req_lock[pick_idx];
            wr_valid_reg   <= 1'b1;
            busy_reg       <= 1'b1;
            state_reg      <= ARB_ISSUE;
          end else if (lock_valid_reg && !req_lock[lock_owner_reg]) begin
            lock_valid_reg <= 1'b0;
          end
        end
        ARB_ISSUE: begin
          if (handshake) begin
            wr_valid_reg <= 1'b0;
            busy_reg     <= 1'b0;
            state_reg    <= ARB_IDLE;
          end
        end
        default: begin
          wr_valid_reg <= 1'b0;
          busy_reg     <= 1'b0;
          state_reg    <= ARB_IDLE;
        end
      endcase
    end
  end

  assign wr_valid   = wr_valid_reg;
  assign wr_addr    = wr_addr_reg;
  assign wr_payload = wr_payload_reg;
  assign wr_reset   = wr_reset_reg;
  assign grant_id   = grant_id_reg;
  assign busy       = busy_reg;

endmodule

// File: tb/tb_scanchain_write_arbiter.sv
// Directed bench for scanchain_write_arbiter with two requesters.
module tb_scanchain_write_arbiter;

  localparam int NR = 2;
  localparam int AB = 12;
  localparam int PB = 169;
  localparam int IB = 1;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [NR-1:0]     req_valid = '0;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_lock = '0;
  logic [NR*AB-1:0]  req_addr = '0;
  logic [NR*PB-1:0]  req_payload = '0;
  logic [NR-1:0]     req_reset = '0;
  logic              wr_valid;
  logic              wr_ready = 1'b0;
  logic [AB-1:0]     wr_addr;
  logic [PB-1:0]     wr_payload;
  logic              wr_reset;
  logic [IB-1:0]     grant_id;
  logic              busy;

  int tests_run = 0;
  int tests_failed = 0;

  scanchain_write_arbiter #(
    .NUM_REQ      (NR),
    .ADDR_BITS    (AB),
    .PAYLOAD_BITS (PB),
    .ID_BITS      (IB)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_lock    (req_lock),
    .req_addr    (req_addr),
    .req_payload (req_payload),
    .req_reset   (req_reset),
    .wr_valid    (wr_valid),
    .wr_ready    (wr_ready),
    .wr_addr     (wr_addr),
    .wr_payload  (wr_payload),
    .wr_reset    (wr_reset),
    .grant_id    (grant_id),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #2;
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_valid got=%0b exp=0", wr_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL reset_grant_id got=%0d exp=0", grant_id); end
    tests_run++; if (wr_addr !== 12'h000) begin tests_failed++; $display("FAIL reset_wr_addr got=%h exp=000", wr_addr); end
    tests_run++; if (wr_reset !== 1'b0) begin tests_failed++; $display("FAIL reset_wr_reset got=%0b exp=0", wr_reset); end
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    $display("[TB] reset released");
  endtask

  task automatic test_single();
    req_addr[1*AB +: AB]    = 12'h0A5;
    req_payload[1*PB +: PB] = 169'h1;
    req_valid = 2'b10;
    wr_ready  = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL single_req_ready got=%b exp=10", req_ready); end
    tick();
    req_valid = 2'b00;
    tests_run++; if (wr_valid !== 1'b1) begin tests_failed++; $display("FAIL single_wr_valid got=%0b exp=1", wr_valid); end
    tests_run++; if (wr_addr !== 12'h0A5) begin tests_failed++; $display("FAIL single_wr_addr got=%h exp=0a5", wr_addr); end
    tests_run++; if (wr_payload !== 169'h1) begin tests_failed++; $display("FAIL single_wr_payload got=%h exp=1", wr_payload); end
    tests_run++; if (grant_id !== 1'b1) begin tests_failed++; $display("FAIL single_grant_id got=%0d exp=1", grant_id); end
    tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL single_ready_in_issue got=%b exp=00", req_ready); end
    tick();
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL single_back_idle_valid got=%0b exp=0", wr_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL single_back_idle_busy got=%0b exp=0", busy); end
    $display("[TB] single request: grant_id=%0d addr=%h", grant_id, wr_addr);
  endtask

  task automatic test_contention();
    logic [IB-1:0]  exp_id;
    logic [NR-1:0]  exp_ready;
    logic [AB-1:0]  exp_addr;
    logic [PB-1:0]  exp_pl;
    req_addr[0*AB +: AB]    = 12'h100;
    req_addr[1*AB +: AB]    = 12'h200;
    req_payload[0*PB +: PB] = 169'h10;
    req_payload[1*PB +: PB] = 169'h20;
    req_valid = 2'b11;
    wr_ready  = 1'b1;
    #1;
    for (int g = 0; g < 4; g++) begin
      exp_id    = IB'(g % 2);
      exp_ready = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_addr  = (g % 2 == 0) ? 12'h100 : 12'h200;
      exp_pl    = (g % 2 == 0) ? 169'h10 : 169'h20;
      tests_run++; if (req_ready !== exp_ready) begin tests_failed++; $display("FAIL contention_ready[%0d] got=%b exp=%b", g, req_ready, exp_ready); end
      tick();
      tests_run++; if (grant_id !== exp_id) begin tests_failed++; $display("FAIL contention_grant[%0d] got=%0d exp=%0d", g, grant_id, exp_id); end
      tests_run++; if (wr_addr !== exp_addr) begin tests_failed++; $display("FAIL contention_addr[%0d] got=%h exp=%h", g, wr_addr, exp_addr); end
      tests_run++; if (wr_payload !== exp_pl) begin tests_failed++; $display("FAIL contention_payload[%0d] got=%h exp=%h", g, wr_payload, exp_pl); end
      $display("[TB] contention grant %0d -> id=%0d addr=%h", g, grant_id, wr_addr);
      tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_backpressure();
    req_addr[0*AB +: AB]    = 12'h033;
    req_payload[0*PB +: PB] = 169'hABC;
    req_valid = 2'b01;
    wr_ready  = 1'b0;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL bp_ready_idle got=%b exp=01", req_ready); end
    tick();
    req_valid = 2'b11;
    for (int c = 0; c < 50; c++) begin
      tests_run++; if (wr_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_wr_valid[%0d] got=%0b exp=1", c, wr_valid); end
      tests_run++; if (wr_addr !== 12'h033) begin tests_failed++; $display("FAIL bp_wr_addr[%0d] got=%h exp=033", c, wr_addr); end
      tests_run++; if (wr_payload !== 169'hABC) begin tests_failed++; $display("FAIL bp_wr_payload[%0d] got=%h exp=abc", c, wr_payload); end
      tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL bp_busy[%0d] got=%0b exp=1", c, busy); end
      tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL bp_req_ready[%0d] got=%b exp=00", c, req_ready); end
      tick();
    end
    req_valid = 2'b00;
    wr_ready  = 1'b1;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL bp_release_busy got=%0b exp=0", busy); end
    $display("[TB] backpressure: 50 stalled cycles then released");
  endtask

  task automatic test_lock();
    // ptr now points at requester 1; the lock must override it
    req_addr[0*AB +: AB]    = 12'h000;
    req_payload[0*PB +: PB] = 169'h5;
    req_addr[1*AB +: AB]    = 12'h3FF;
    req_payload[1*PB +: PB] = 169'h7;
    req_valid = 2'b01;
    req_lock  = 2'b01;
    req_reset = 2'b01;
    wr_ready  = 1'b1;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL lock_first_ready got=%b exp=01", req_ready); end
    tick();
    tests_run++; if (wr_reset !== 1'b1) begin tests_failed++; $display("FAIL lock_reset_flag got=%0b exp=1", wr_reset); end
    tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL lock_first_grant got=%0d exp=0", grant_id); end
    $display("[TB] lock write 0: reset cmd id=%0d", grant_id);
    req_valid = 2'b11;
    req_reset = 2'b00;
    req_addr[0*AB +: AB] = 12'h001;
    tick();
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL lock_hold_ready got=%b exp=01", req_ready); end
    tick();
    tests_run++; if (wr_addr !== 12'h001) begin tests_failed++; $display("FAIL lock_w1_addr got=%h exp=001", wr_addr); end
    tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL lock_w1_grant got=%0d exp=0", grant_id); end
    tests_run++; if (wr_reset !== 1'b0) begin tests_failed++; $display("FAIL lock_w1_reset got=%0b exp=0", wr_reset); end
    $display("[TB] lock write 1: addr=%h id=%0d", wr_addr, grant_id);
    req_valid = 2'b10;
    tick();
    for (int c = 0; c < 3; c++) begin
      tests_run++; if (req_ready !== 2'b00) begin tests_failed++; $display("FAIL lock_stall_ready[%0d] got=%b exp=00", c, req_ready); end
      tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL lock_stall_busy[%0d] got=%0b exp=0", c, busy); end
      tick();
    end
    req_valid = 2'b11;
    req_addr[0*AB +: AB] = 12'h002;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL lock_w2_ready got=%b exp=01", req_ready); end
    tick();
    tests_run++; if (wr_addr !== 12'h002) begin tests_failed++; $display("FAIL lock_w2_addr got=%h exp=002", wr_addr); end
    $display("[TB] lock write 2: addr=%h id=%0d", wr_addr, grant_id);
    req_lock  = 2'b00;
    req_valid = 2'b10;
    tick();
    tests_run++; if (req_ready !== 2'b10) begin tests_failed++; $display("FAIL lock_release_ready got=%b exp=10", req_ready); end
    tick();
    tests_run++; if (grant_id !== 1'b1) begin tests_failed++; $display("FAIL lock_release_grant got=%0d exp=1", grant_id); end
    tests_run++; if (wr_addr !== 12'h3FF) begin tests_failed++; $display("FAIL lock_release_addr got=%h exp=3ff", wr_addr); end
    $display("[TB] lock released: id=%0d addr=%h", grant_id, wr_addr);
    req_valid = 2'b00;
    tick();
  endtask

  task automatic test_drop();
    req_valid = 2'b01;
    #1;
    tests_run++; if (req_ready !== 2'b01) begin tests_failed++; $display("FAIL drop_ready got=%b exp=01", req_ready); end
    #1;
    req_valid = 2'b00;
    tick();
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL drop_busy got=%0b exp=0", busy); end
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL drop_wr_valid got=%0b exp=0", wr_valid); end
    $display("[TB] dropped request: busy=%0b", busy);
  endtask

  task automatic test_async_reset();
    req_addr[1*AB +: AB] = 12'h0C3;
    req_valid = 2'b10;
    wr_ready  = 1'b0;
    tick();
    req_valid = 2'b00;
    tests_run++; if (grant_id !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_grant got=%0d exp=1", grant_id); end
    tests_run++; if (wr_valid !== 1'b1) begin tests_failed++; $display("FAIL areset_pre_valid got=%0b exp=1", wr_valid); end
    #2;
    reset_n = 1'b0;
    #1;
    tests_run++; if (wr_valid !== 1'b0) begin tests_failed++; $display("FAIL areset_wr_valid got=%0b exp=0", wr_valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL areset_busy got=%0b exp=0", busy); end
    tests_run++; if (grant_id !== 1'b0) begin tests_failed++; $display("FAIL areset_grant_id got=%0d exp=0", grant_id); end
    tests_run++; if (wr_addr !== 12'h000) begin tests_failed++; $display("FAIL areset_wr_addr got=%h exp=000", wr_addr); end
    #1;
    reset_n = 1'b1;
    tick();
    $display("[TB] async reset mid-issue: wr_valid=%0b busy=%0b", wr_valid, busy);
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_lock();
    test_drop();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
